// File: rtl/operand_pkg.sv
// Shared encodings and default widths for the operand-A fetch stage.
package operand_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    localparam logic [1:0] SEL_RS  = 2'd0;
    localparam logic [1:0] SEL_IMU = 2'd1;
    localparam logic [1:0] SEL_IMZ = 2'd2;
    localparam logic [1:0] SEL_PC  = 2'd3;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_RF   = 2'd1;
    localparam logic [1:0] SRC_EX   = 2'd2;
    localparam logic [1:0] SRC_MEM  = 2'd3;

endpackage

// File: rtl/fwd_resolve.sv
// Resolves the rs1 value against the EX and MEM bypass channels.
import operand_pkg::*;

module fwd_resolve #(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            ex_valid,
    input  logic [RA_W-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_valid,
    input  logic [RA_W-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] res_data,
    output logic [1:0]      res_src
);

    logic rs_zero;
    logic ex_hit;
    logic mem_hit;

    // x0 never matches, so a bypass tagged with address 0 is inert
    assign rs_zero = (rs_addr == '0);
    assign ex_hit  = ex_valid && (ex_addr != '0) && (ex_addr == rs_addr);
    assign mem_hit = mem_valid && (mem_addr != '0) && (mem_addr == rs_addr);

    always_comb begin
        res_data = rs_data;
        res_src  = SRC_RF;
        if (rs_zero) begin
            res_data = '0;
            res_src  = SRC_NONE;
        end else if (ex_hit) begin
            res_data = ex_data;
            res_src  = SRC_EX;
        end else if (mem_hit) begin
            res_data = mem_data;
            res_src  = SRC_MEM;
        end
    end

endmodule

// File: rtl/operand_a_stage.sv
// Operand-A source select with bypass and a single-entry valid/ready register.
import operand_pkg::*;

module operand_a_stage #(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [RA_W-1:0] in_rs_addr,
    input  logic [XLEN-1:0] in_rs_data,
    input  logic [XLEN-1:0] in_imz,
    input  logic [XLEN-1:0] in_imu,
    input  logic [XLEN-1:0] in_pc,
    input  logic            fwd_ex_valid,
    input  logic [RA_W-1:0] fwd_ex_addr,
    input  logic [XLEN-1:0] fwd_ex_data,
    input  logic            fwd_mem_valid,
    input  logic [RA_W-1:0] fwd_mem_addr,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [1:0]      out_src
);

    logic [XLEN-1:0] rs_val;
    logic [1:0]      rs_src;
    logic [XLEN-1:0] sel_data;
    logic [1:0]      sel_src;

    logic            valid_d, valid_q;
    logic [XLEN-1:0] data_d, data_q;
    logic [1:0]      src_d, src_q;
    logic            accept;

    fwd_resolve #(
        .XLEN(XLEN),
        .RA_W(RA_W)
    ) u_fwd (
        .rs_addr  (in_rs_addr),
        .rs_data  (in_rs_data),
        .ex_valid (fwd_ex_valid),
        .ex_addr  (fwd_ex_addr),
        .ex_data  (fwd_ex_data),
        .mem_valid(fwd_mem_valid),
        .mem_addr (fwd_mem_addr),
        .mem_data (fwd_mem_data),
        .res_data (rs_val),
        .res_src  (rs_src)
    );

    always_comb begin
        sel_data = rs_val;
        sel_src  = rs_src;
        unique case (in_sel)
            SEL_RS: begin
                sel_data = rs_val;
                sel_src  = rs_src;
            end
            SEL_IMU: begin
                sel_data = in_imu;
                sel_src  = SRC_NONE;
            end
            SEL_IMZ: begin
                sel_data = in_imz;
                sel_src  = SRC_NONE;
            end
            SEL_PC: begin
                sel_data = in_pc;
                sel_src  = SRC_NONE;
            end
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // flush wins over both a new load and a drain
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            src_d   = sel_src;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= SRC_NONE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_operand_a_stage.sv
// Directed scoreboard bench for operand_a_stage.
module tb_operand_a_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [4:0]  in_rs_addr;
    logic [31:0] in_rs_data;
    logic [31:0] in_imz;
    logic [31:0] in_imu;
    logic [31:0] in_pc;
    logic        fwd_ex_valid;
    logic [4:0]  fwd_ex_addr;
    logic [31:0] fwd_ex_data;
    logic        fwd_mem_valid;
    logic [4:0]  fwd_mem_addr;
    logic [31:0] fwd_mem_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_src;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic m_valid = 1'b0;
    exp_t held = '0;

    operand_a_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_rs_addr   (in_rs_addr),
        .in_rs_data   (in_rs_data),
        .in_imz       (in_imz),
        .in_imu       (in_imu),
        .in_pc        (in_pc),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_addr  (fwd_ex_addr),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_mem_valid(fwd_mem_valid),
        .fwd_mem_addr (fwd_mem_addr),
        .fwd_mem_data (fwd_mem_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the currently driven inputs; e is the operand
    // this request should produce if the stage accepts it.
    task automatic tick(input string tag, input logic [31:0] ed, input logic [1:0] es);
        logic rdy;
        logic acc;
        exp_t got;
        #1;
        rdy = !m_valid || out_ready;
        chk({tag, "/in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        acc = in_valid && rdy && !flush;
        if (acc) sb.push_back('{data: ed, src: es});
        @(posedge clk);
        #1;
        if (flush) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        chk({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        if (acc) begin
            if (sb.size() == 0) begin
                chk({tag, "/sb_empty"}, 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                held = got;
                chk({tag, "/data"}, out_data, got.data);
                chk({tag, "/src"}, {30'd0, out_src}, {30'd0, got.src});
            end
        end else if (m_valid) begin
            chk({tag, "/hold_data"}, out_data, held.data);
            chk({tag, "/hold_src"}, {30'd0, out_src}, {30'd0, held.src});
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_sel = 0; in_rs_addr = 0; in_rs_data = 0;
        in_imz = 0; in_imu = 0; in_pc = 0;
        fwd_ex_valid = 0; fwd_ex_addr = 0; fwd_ex_data = 0;
        fwd_mem_valid = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
        flush = 0; out_ready = 1;
        #2;
        chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst/out_data", out_data, 32'd0);
        chk("rst/out_src", {30'd0, out_src}, 32'd0);
        chk("rst/in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        in_valid = 1; in_sel = 2'd3; in_pc = 32'h0000_1000;
        tick("pc", 32'h0000_1000, 2'd0);

        in_sel = 2'd0; in_rs_addr = 5; in_rs_data = 32'h11;
        fwd_ex_valid = 1; fwd_ex_addr = 5; fwd_ex_data = 32'h22;
        fwd_mem_valid = 1; fwd_mem_addr = 5; fwd_mem_data = 32'h33;
        tick("ex_prio", 32'h22, 2'd2);
        fwd_ex_valid = 0;
        tick("mem_fwd", 32'h33, 2'd3);
        fwd_mem_valid = 0;
        tick("rf", 32'h11, 2'd1);

        in_rs_addr = 0; in_rs_data = 32'hDEAD;
        fwd_ex_valid = 1; fwd_ex_addr = 0; fwd_ex_data = 32'hBEEF;
        tick("x0", 32'h0, 2'd0);

        in_rs_addr = 3; in_rs_data = 32'h99;
        fwd_ex_valid = 1; fwd_ex_addr = 7; fwd_ex_data = 32'h77;
        fwd_mem_valid = 1; fwd_mem_addr = 3; fwd_mem_data = 32'h44;
        tick("ex_miss", 32'h44, 2'd3);

        in_sel = 2'd1; in_imu = 32'h1234_5000;
        fwd_ex_addr = 3;
        tick("imu", 32'h1234_5000, 2'd0);
        in_sel = 2'd2; in_imz = 32'h1F;
        tick("imz", 32'h1F, 2'd0);

        in_valid = 0;
        tick("drain", 32'h0, 2'd0);

        in_valid = 1; in_sel = 2'd1; in_imu = 32'hAA; out_ready = 0;
        tick("load_aa", 32'hAA, 2'd0);
        in_imu = 32'hBB;
        tick("stall1", 32'hBB, 2'd0);
        in_sel = 2'd0; in_rs_addr = 3; fwd_ex_data = 32'h5555;
        tick("stall2", 32'h5555, 2'd2);
        in_sel = 2'd1; out_ready = 1;
        tick("take_bb", 32'hBB, 2'd0);

        for (int i = 1; i <= 3; i++) begin
            in_imu = i;
            tick("b2b", i, 2'd0);
        end

        flush = 1; in_imu = 32'h77;
        tick("flush", 32'h77, 2'd0);
        flush = 0;

        out_ready = 0; in_imu = 32'h55;
        tick("load_55", 32'h55, 2'd0);
        in_valid = 0;
        #2 reset = 1'b1;
        #1;
        chk("arst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst/out_data", out_data, 32'd0);
        chk("arst/out_src", {30'd0, out_src}, 32'd0);
        chk("arst/in_ready", {31'd0, in_ready}, 32'd1);
        m_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1; in_imu = 32'h66;
        tick("post_rst", 32'h66, 2'd0);

        chk("sb_left", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_a_stage.md
OPERAND_A_STAGE -- requirements
Module: operand_a_stage

Interface
REQ-001 Parameter XLEN, default 32, operand/data width in bits.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an operand request.
REQ-006 in_ready  output  1  stage accepts the request this cycle.
REQ-007 in_sel  input  2  source select: 0 RS, 1 IMU, 2 IMZ, 3 PC.
REQ-008 in_rs_addr  input  RA_W  rs1 address of the request.
REQ-009 in_rs_data  input  XLEN  register-file read value for rs1.
REQ-010 in_imz  input  XLEN  zero-extended CSR immediate.
REQ-011 in_imu  input  XLEN  U-type immediate.
REQ-012 in_pc  input  XLEN  PC of the request.
REQ-013 fwd_ex_valid / fwd_ex_addr / fwd_ex_data  input  1/RA_W/XLEN  EX-stage bypass channel.
REQ-014 fwd_mem_valid / fwd_mem_addr / fwd_mem_data  input  1/RA_W/XLEN  MEM-stage bypass channel.
REQ-015 flush  input  1  discard held and incoming operand.
REQ-016 out_valid  output  1  registered operand is valid.
REQ-017 out_ready  input  1  downstream ALU consumes the operand.
REQ-018 out_data  output  XLEN  registered operand A.
REQ-019 out_src  output  2  registered origin: 0 none/immediate/PC, 1 register file, 2 EX bypass, 3 MEM bypass.

Function
REQ-020 Selected value SHALL be: sel 0 -> resolved rs1 value (REQ-021); sel 1 -> in_imu; sel 2 -> in_imz; sel 3 -> in_pc.
REQ-021 For sel 0, resolved value SHALL be: 0 if in_rs_addr==0; else fwd_ex_data if fwd_ex_valid and fwd_ex_addr==in_rs_addr; else fwd_mem_data if fwd_mem_valid and addresses match; else in_rs_data.
REQ-022 EX bypass SHALL take priority over MEM bypass when both match.
REQ-023 Bypass channels with address 0 SHALL never match.
REQ-024 Bypass SHALL be evaluated only for sel 0; out_src SHALL be 0 for sel 1..3 and for rs address 0.
REQ-025 in_ready SHALL equal (!out_valid || out_ready), combinationally, and SHALL NOT depend on in_valid.
REQ-026 On a rising edge with in_valid && in_ready && !flush: out_data, out_src load the selected value/origin and out_valid becomes 1 (latency one cycle).
REQ-027 On a rising edge with out_valid && out_ready and no new load: out_valid becomes 0; out_data, out_src hold.
REQ-028 While out_valid && !out_ready: out_data, out_src, out_valid SHALL hold unchanged regardless of bypass inputs.
REQ-029 Simultaneous consume and accept SHALL load the new operand with out_valid staying 1 (full throughput, no bubble).
REQ-030 flush SHALL take priority: next cycle out_valid=0; a request presented in the same cycle is dropped.
REQ-031 Stage SHALL hold at most one operand; no additional buffering.

Reset
REQ-032 reset asserted SHALL immediately force out_valid=0, out_data=0, out_src=0, independent of clk.
REQ-033 Reset mid-transfer SHALL drop the held operand; first accept after deassertion behaves as REQ-026.
REQ-034 in_ready SHALL be 1 while reset is asserted and on the first cycle after it.

Structure
REQ-035 Package operand_pkg SHALL hold sel encodings (SEL_RS, SEL_IMU, SEL_IMZ, SEL_PC), out_src encodings, and default XLEN/RA_W.
REQ-036 Bypass resolution (REQ-021..023) SHALL be a combinational sub-module fwd_resolve; the source mux and handshake register remain in operand_a_stage.

Verification
REQ-037 sel=3, in_pc=0x0000_1000, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_1000, out_src=0.
REQ-038 sel=0, rs_addr=5, rs_data=0x11, EX(5,0x22) and MEM(5,0x33) valid -> out_data=0x22, out_src=2; EX invalid -> 0x33, src=3; neither -> 0x11, src=1.
REQ-039 sel=0, rs_addr=0, rs_data=0xDEAD, EX(0,0xBEEF) valid -> out_data=0, out_src=0.
REQ-040 out_ready=0 after load of 0xAA, new request 0xBB offered -> in_ready=0, out_data stays 0xAA; out_ready=1 with 0xBB valid -> next cycle out_data=0xBB, out_valid=1.
REQ-041 Back-to-back requests 1,2,3 with out_ready=1 -> one operand per cycle, out_valid never drops.
REQ-042 flush with in_valid=1, then reset asserted mid-hold -> out_valid=0 after flush edge; reset immediately forces out_data=0, out_valid=0.
